// File: rtl/bus_arb_pkg.sv
// Shared types and sizes for the split-capable bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

  localparam int MAX_MASTERS = 4;
  localparam int OWNER_W     = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_RESUME = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arb_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Latency: combinational.
// Backpressure: none; the caller masks ineligible requesters before encoding.
// Ports: req (eligible request vector), vld (any request), idx (winning index).
module bus_arb_prio_enc
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  output logic                   vld,
  output logic [OWNER_W-1:0]     idx
);

  // Scan from the top down so the last hit (lowest index) is the one kept.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = OWNER_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_split_arbiter.sv
// Shared-bus arbiter (master 0 highest) with one parked split transaction for the bridge slave.
// Latency: req in cycle N -> grant in N+1; every release is followed by one all-idle turnaround cycle.
// Backpressure: masters hold req until ack; the parked master is masked until split_req resumes it.
// Ports: clk, rst_n; req/grant/owner/bus_busy toward the masters; ack, split_ack, split_req in
//   from the slave side; split_grant, split_pending, timeout_err (pulse), split_ovf (sticky) out.
module bus_split_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [OWNER_W-1:0]     owner,
  output logic                   bus_busy,
  input  logic                   ack,
  input  logic                   split_ack,
  input  logic                   split_req,
  output logic                   split_grant,
  output logic                   split_pending,
  output logic                   timeout_err,
  output logic                   split_ovf
);

  // Counter only needs to reach GRANT_TIMEOUT-1, then saturates.
  localparam int                 CNT_W    = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);
  localparam bit                 WDOG_EN  = (GRANT_TIMEOUT > 0);

  arb_state_t               state_q, state_nxt;
  logic [OWNER_W-1:0]       owner_q, owner_nxt;
  logic [OWNER_W-1:0]       parked_q, parked_nxt;
  logic [CNT_W-1:0]         cnt_q, cnt_nxt;
  logic [NUM_MASTERS-1:0]   grant_q, grant_nxt;
  logic                     busy_q, sgrant_q, sgrant_nxt;
  logic                     pending_q, pending_nxt;
  logic                     terr_q, terr_nxt;
  logic                     ovf_q, ovf_nxt;

  logic [NUM_MASTERS-1:0]   elig;
  logic                     enc_vld;
  logic [OWNER_W-1:0]       enc_idx;
  logic                     owner_req;
  logic                     wdog_fire;
  logic                     release_bus;
  logic [OWNER_W-1:0]       sel_idx;
  logic                     sel_load;

  // Parked master stays invisible to arbitration until it is resumed.
  always_comb begin
    elig      = '0;
    owner_req = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      elig[i] = req[i] && !(pending_q && (parked_q == OWNER_W'(i)));
      if (owner_q == OWNER_W'(i)) owner_req = req[i];
    end
  end

  bus_arb_prio_enc #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_prio_enc (
    .req (elig),
    .vld (enc_vld),
    .idx (enc_idx)
  );

  assign wdog_fire = WDOG_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_nxt   = state_q;
    owner_nxt   = owner_q;
    parked_nxt  = parked_q;
    pending_nxt = pending_q;
    ovf_nxt     = ovf_q;
    sgrant_nxt  = sgrant_q;
    grant_nxt   = grant_q;
    terr_nxt    = 1'b0;
    cnt_nxt     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    release_bus = 1'b0;
    sel_idx     = '0;
    sel_load    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        cnt_nxt = '0;
        // Returning the parked transfer takes precedence over new requests.
        if (pending_q && split_req) begin
          state_nxt  = ARB_RESUME;
          sgrant_nxt = 1'b1;
          sel_idx    = parked_q;
          sel_load   = 1'b1;
        end else if (enc_vld) begin
          state_nxt = ARB_GRANT;
          sel_idx   = enc_idx;
          sel_load  = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (ack) begin
          release_bus = 1'b1;
        end else if (split_ack) begin
          // Only one parking slot: a second split is closed out and flagged.
          if (pending_q) begin
            ovf_nxt = 1'b1;
          end else begin
            parked_nxt  = owner_q;
            pending_nxt = 1'b1;
          end
          release_bus = 1'b1;
        end else if (!owner_req) begin
          release_bus = 1'b1;
        end else if (wdog_fire) begin
          terr_nxt    = 1'b1;
          release_bus = 1'b1;
        end
      end
      ARB_RESUME: begin
        if (ack) begin
          pending_nxt = 1'b0;
          release_bus = 1'b1;
        end else if (!split_req) begin
          release_bus = 1'b1;
        end else if (wdog_fire) begin
          pending_nxt = 1'b0;
          terr_nxt    = 1'b1;
          release_bus = 1'b1;
        end
      end
      default: begin
        release_bus = 1'b1;
      end
    endcase

    if (sel_load) begin
      owner_nxt = sel_idx;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        grant_nxt[i] = (sel_idx == OWNER_W'(i));
      end
    end

    if (release_bus) begin
      state_nxt  = ARB_IDLE;
      grant_nxt  = '0;
      sgrant_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      parked_q  <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      sgrant_q  <= 1'b0;
      pending_q <= 1'b0;
      terr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      owner_q   <= owner_nxt;
      parked_q  <= parked_nxt;
      cnt_q     <= cnt_nxt;
      grant_q   <= grant_nxt;
      busy_q    <= |grant_nxt;
      sgrant_q  <= sgrant_nxt;
      pending_q <= pending_nxt;
      terr_q    <= terr_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  assign grant         = grant_q;
  assign owner         = owner_q;
  assign bus_busy      = busy_q;
  assign split_grant   = sgrant_q;
  assign split_pending = pending_q;
  assign timeout_err   = terr_q;
  assign split_ovf     = ovf_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Bench for bus_split_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_bus_split_arbiter;

  localparam int NM = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NM-1:0] req;
  logic [NM-1:0] grant;
  logic [1:0]    owner;
  logic          bus_busy;
  logic          ack, split_ack, split_req;
  logic          split_grant, split_pending, timeout_err, split_ovf;

  int vectors     = 0;
  int miscompares = 0;

  // Model: who holds the bus (-1 none), whether it is a resumed split,
  // which master is parked (-1 none), how long the bus has been held.
  int m_owner, m_parked, m_age;
  bit m_resume, m_terr, m_ovf;

  bus_split_arbiter #(
    .NUM_MASTERS   (NM),
    .GRANT_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .grant         (grant),
    .owner         (owner),
    .bus_busy      (bus_busy),
    .ack           (ack),
    .split_ack     (split_ack),
    .split_req     (split_req),
    .split_grant   (split_grant),
    .split_pending (split_pending),
    .timeout_err   (timeout_err),
    .split_ovf     (split_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_parked = -1;
    m_age    = 0;
    m_resume = 0;
    m_terr   = 0;
    m_ovf    = 0;
  endtask

  task automatic free_bus();
    m_owner  = -1;
    m_resume = 0;
  endtask

  // Applies the current inputs as seen at the coming clock edge.
  task automatic model_step();
    int pick;
    m_terr = 0;
    if (m_owner < 0) begin
      pick = -1;
      for (int i = NM - 1; i >= 0; i--)
        if (req[i] && i != m_parked) pick = i;
      if (m_parked >= 0 && split_req) begin
        m_owner  = m_parked;
        m_resume = 1;
        m_age    = 0;
      end else if (pick >= 0) begin
        m_owner  = pick;
        m_resume = 0;
        m_age    = 0;
      end
    end else if (ack) begin
      if (m_resume) m_parked = -1;
      free_bus();
    end else if (!m_resume && split_ack) begin
      if (m_parked >= 0) m_ovf = 1;
      else m_parked = m_owner;
      free_bus();
    end else if (m_resume ? !split_req : !req[m_owner]) begin
      free_bus();
    end else if (m_age == TO - 1) begin
      if (m_resume) m_parked = -1;
      m_terr = 1;
      free_bus();
    end else begin
      m_age++;
    end
  endtask

  task automatic check_all();
    chk("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("bus_busy", 32'(bus_busy), 32'(m_owner >= 0));
    chk("split_grant", 32'(split_grant), 32'(m_resume));
    chk("split_pending", 32'(split_pending), 32'(m_parked >= 0));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("split_ovf", 32'(split_ovf), 32'(m_ovf));
    if (m_owner >= 0) chk("owner", 32'(owner), 32'(m_owner));
  endtask

  // Inputs are driven at the falling edge; outputs are checked at the next one.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; ack = 0; split_ack = 0; split_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    chk("rst_split", 32'({split_grant, split_pending, timeout_err, split_ovf}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: two requests, master 0 first, turnaround cycle then master 1.
    req = 2'b11; tick();
    chk("t1_grant_m0", 32'(grant), 32'h1);
    tick(); tick(); tick();
    ack = 1; req = 2'b10; tick();
    chk("t1_gap", 32'(grant), 32'h0);
    ack = 0; tick();
    chk("t1_grant_m1", 32'(grant), 32'h2);
    ack = 1; req = 2'b00; tick();
    ack = 0; tick();

    // 2: park master 0, master 1 gets the bus, master 0 not regranted.
    req = 2'b01; tick();
    split_ack = 1; tick();
    chk("t2_parked", 32'({grant, split_pending}), 32'b001);
    split_ack = 0; req = 2'b11; tick();
    chk("t2_grant_m1", 32'(grant), 32'h2);
    ack = 1; req = 2'b01; tick();
    ack = 0; tick();
    chk("t2_m0_masked", 32'(grant), 32'h0);

    // 3: resume the parked master, completion clears the split.
    split_req = 1; tick();
    chk("t3_resume", 32'({grant, split_grant}), 32'b011);
    ack = 1; split_req = 0; req = 2'b00; tick();
    chk("t3_done", 32'({grant, split_grant, split_pending}), 32'd0);
    ack = 0; tick();

    // 4: split_req during another transfer waits; resume beats master 1.
    req = 2'b01; tick();
    split_ack = 1; tick();
    split_ack = 0; req = 2'b10; tick();
    split_req = 1; tick();
    chk("t4_no_preempt", 32'({grant, split_grant}), 32'b100);
    tick();
    ack = 1; tick();
    chk("t4_gap", 32'(grant), 32'h0);
    ack = 0; tick();
    chk("t4_resume_wins", 32'({grant, split_grant}), 32'b011);
    ack = 1; split_req = 0; tick();
    ack = 0; tick();
    chk("t4_m1_after", 32'(grant), 32'h2);
    req = 2'b00; tick();

    // 5: watchdog revokes a grant held without ack.
    req = 2'b10; tick();
    chk("t5_granted", 32'(grant), 32'h2);
    for (int k = 0; k < TO - 1; k++) tick();
    chk("t5_still_held", 32'({grant, timeout_err}), 32'b100);
    tick();
    chk("t5_revoked", 32'({grant, timeout_err}), 32'b001);
    req = 2'b00; tick();
    chk("t5_pulse_end", 32'(timeout_err), 32'd0);

    // 6: second split while one is parked, then async reset mid-grant.
    req = 2'b01; tick();
    split_ack = 1; tick();
    split_ack = 0; req = 2'b10; tick();
    split_ack = 1; tick();
    chk("t6_ovf", 32'({grant, split_pending, split_ovf}), 32'b0011);
    split_ack = 0; req = 2'b00; tick();
    chk("t6_ovf_sticky", 32'(split_ovf), 32'd1);
    req = 2'b10; tick();
    chk("t6_busy", 32'(grant), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'({grant, bus_busy, split_grant}), 32'd0);
    chk("t6_async_flags", 32'({split_pending, split_ovf, timeout_err}), 32'd0);
    model_reset();
    @(negedge clk);
    req = '0; ack = 0; split_ack = 0; split_req = 0;
    rst_n = 1'b1;
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) req = NM'($urandom_range((1 << NM) - 1));
      ack       = ($urandom_range(7) == 0);
      split_ack = ($urandom_range(9) == 0);
      if ($urandom_range(5) == 0) split_req = ~split_req;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
